barrett_reduce_pipe: RTL



---
 rtl/kyber_pkg.sv | 8 +
 rtl/cond_sub_q.sv | 10 +
 rtl/barrett_reduce_pipe.sv | 72 +++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: constants shared by the Kyber multiplier, reducer and butterfly blocks
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int BARRETT_M = 5039;
  localparam int BARRETT_SHIFT = 24;
  localparam int COEF_W = 12;
  localparam int PROD_W = 24;
endpackage

// File: rtl/cond_sub_q.sv
// cond_sub_q: maps a value in [0, 2Q) to [0, Q) with one conditional subtract
module cond_sub_q import kyber_pkg::*; #(
  parameter int Q = KYBER_Q,
  parameter int W = COEF_W
) (
  input  logic [W:0]   a,
  output logic [W-1:0] y
);
  assign y = W'(a >= (W+1)'(Q) ? a - (W+1)'(Q) : a);
endmodule

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: 3-stage Barrett reduction of a raw product mod Q with valid/ready and tag sideband
module barrett_reduce_pipe import kyber_pkg::*; #(
  parameter int Q = KYBER_Q,
  parameter int IN_W = PROD_W,
  parameter int OUT_W = COEF_W,
  parameter int M = BARRETT_M,
  parameter int SHIFT = BARRETT_SHIFT,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_coef,
  output logic [TAG_W-1:0] out_tag
);
  localparam int MW = $clog2(M + 1);
  localparam int PW = IN_W + MW;
  localparam int TW = PW - SHIFT;
  localparam int RW = OUT_W + 1;
  logic v1, v2, v3, ld1, ld2, ld3;
  logic [IN_W-1:0] p1, tq;
  logic [PW-1:0] prod1;
  logic [TAG_W-1:0] tag1, tag2;
  logic [TW-1:0] t;
  logic [RW-1:0] r0;
  logic [OUT_W-1:0] r;
  // each stage loads when empty or when its successor loads, so bubbles collapse
  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready = ld1;
  assign out_valid = v3;
  assign t = TW'(prod1 >> SHIFT);
  assign tq = IN_W'(t) * IN_W'(Q);
  cond_sub_q #(.Q(Q), .W(OUT_W)) u_sub (.a(r0), .y(r));
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      p1 <= '0;
      prod1 <= '0;
      tag1 <= '0;
      r0 <= '0;
      tag2 <= '0;
      out_coef <= '0;
      out_tag <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld1 && in_valid) begin
        p1 <= in_prod;
        prod1 <= PW'(in_prod) * PW'(M);
        tag1 <= in_tag;
      end
      if (ld2 && v1) begin
        r0 <= RW'(p1 - tq);
        tag2 <= tag1;
      end
      if (ld3 && v2) begin
        out_coef <= r;
        out_tag <= tag2;
      end
    end
  end
endmodule
